// File: rtl/mdu_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [63:0] ALL_ONES = '1;

    function automatic logic is_div(mdu_op_t op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(mdu_op_t op);
        case (op)
            OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_a(mdu_op_t op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
            OP_MULW, OP_DIVW, OP_REMW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(mdu_op_t op);
        case (op)
            OP_MULH, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_word(mdu_op_t op);
        case (op)
            OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_high(mdu_op_t op);
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Codes past REMUW are never legal; word ops only when the width supports them.
    function automatic logic is_legal(mdu_op_t op, logic w_en);
        return (op <= OP_REMUW) && (!is_word(op) || w_en);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract.
module mdu_div_step #(
    parameter int N = 64
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // The partial remainder stays below the divisor, so N+1 bits hold the trial exactly.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[N];
        rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Radix-2 iterative RV64M multiply/divide unit with valid/ready handshakes and flush.
// Optional build macro MDU_EARLY_OUT_EN skips iteration for trivially-known results.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int N     = 64,
    parameter bit W_OPS = (N == 64)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  mdu_op_t      op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res
);

    localparam bit            W_EN  = W_OPS && (N == 64);
    localparam int            CW    = $clog2(N) + 1;
    localparam logic [N-1:0]  MIN_N = {1'b1, {(N-1){1'b0}}};

    state_t         state, state_next;
    mdu_op_t        op_q;
    logic [N-1:0]   a_q, b_q, opb, rem, quo;
    logic [2*N-1:0] mcand, acc;
    logic [CW-1:0]  cnt;
    logic           accept, early, legal;
    logic [N-1:0]   a_ext, b_ext, mag_a, mag_b;
    logic           neg_a, neg_b;
    logic [N-1:0]   step_rem;
    logic           step_q;

    function automatic logic [N-1:0] ext32(logic [N-1:0] x, logic sgn);
        logic [N-1:0] r;
        r       = (sgn && x[31]) ? '1 : '0;
        r[31:0] = x[31:0];
        return r;
    endfunction

    function automatic logic sgn_overflow(mdu_op_t f_op, logic [N-1:0] fa, logic [N-1:0] fb);
        if (!(is_div(f_op) && is_signed_a(f_op))) return 1'b0;
        if (is_word(f_op)) return (fa[31:0] == 32'h8000_0000) && (fb[31:0] == 32'hFFFF_FFFF);
        return (fa == MIN_N) && (fb == ALL_ONES[N-1:0]);
    endfunction

    // Sign correction and boundary overrides, shared by the iterative and early-out paths.
    function automatic logic [N-1:0] finalize(mdu_op_t f_op, logic [N-1:0] fa, logic [N-1:0] fb,
                                              logic [2*N-1:0] prod, logic [N-1:0] r_mag,
                                              logic [N-1:0] q_mag);
        logic           na, nb;
        logic [2*N-1:0] p;
        logic [N-1:0]   q, r, v;
        na = is_signed_a(f_op) && fa[N-1];
        nb = is_signed_b(f_op) && fb[N-1];
        p  = (na ^ nb) ? -prod : prod;
        q  = (na ^ nb) ? -q_mag : q_mag;
        r  = na ? -r_mag : r_mag;
        if (fb == '0) begin
            q = ALL_ONES[N-1:0];
            r = fa;
        end else if (sgn_overflow(f_op, fa, fb)) begin
            q = fa;
            r = '0;
        end
        if (!is_legal(f_op, W_EN))  v = '0;
        else if (is_div(f_op))      v = is_rem(f_op) ? r : q;
        else if (is_high(f_op))     v = p[2*N-1:N];
        else                        v = p[N-1:0];
        if (is_word(f_op)) v = ext32(v, 1'b1);
        return v;
    endfunction

    always_comb begin
        a_ext = is_word(op) ? ext32(a, is_signed_a(op)) : a;
        b_ext = is_word(op) ? ext32(b, is_signed_b(op)) : b;
        neg_a = is_signed_a(op) && a_ext[N-1];
        neg_b = is_signed_b(op) && b_ext[N-1];
        mag_a = neg_a ? -a_ext : a_ext;
        mag_b = neg_b ? -b_ext : b_ext;
        legal = is_legal(op, W_EN);
`ifdef MDU_EARLY_OUT_EN
        early = (a_ext == '0) || (b_ext == '0) || sgn_overflow(op, a_ext, b_ext);
`else
        early = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = (!legal || early) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush)                 state_next = IDLE;
                else if (cnt == CW'(1))    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    mdu_div_step #(.N(N)) u_div_step (
        .rem_in  (rem),
        .bit_in  (quo[N-1]),
        .divisor (opb),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Word divides pre-shift the dividend so its 32 bits are consumed MSB-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MUL;
            a_q   <= '0;
            b_q   <= '0;
            opb   <= '0;
            rem   <= '0;
            quo   <= '0;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            op_q  <= op;
            a_q   <= a_ext;
            b_q   <= b_ext;
            opb   <= mag_b;
            rem   <= '0;
            quo   <= is_word(op) ? (mag_a << (N - 32)) : mag_a;
            mcand <= {{N{1'b0}}, mag_a};
            acc   <= '0;
            cnt   <= is_word(op) ? CW'(32) : CW'(N);
        end else if (state == CALC) begin
            if (is_div(op_q)) begin
                rem <= step_rem;
                quo <= {quo[N-2:0], step_q};
            end else begin
                if (opb[0]) acc <= acc + mcand;
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end
            cnt <= cnt - CW'(1);
        end
    end

    assign res = (state == DONE) ? finalize(op_q, a_q, b_q, acc, rem, quo) : '0;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter: results, latency, backpressure, flush and reset.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int N  = 64;
    localparam int FL = 65;
    localparam int WL = 33;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    mdu_op_t      op = OP_MUL;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] res;

    typedef struct {
        logic [N-1:0] res;
        int           lat;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    mdu_iter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    function automatic int el(int full);
        return EARLY ? 1 : full;
    endfunction

    task automatic check_output(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one request, then compares against the scoreboard when out_valid appears.
    task automatic apply_stimulus(string tag, mdu_op_t o, logic [N-1:0] x, logic [N-1:0] y,
                                  logic [N-1:0] exp, int lat, int hold = 0);
        exp_t e;
        int   cyc;
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        sb.push_back('{exp, lat, tag});
        check_output({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() == 0) begin
            check_output({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_output({e.tag, ".lat"}, 64'(cyc), 64'(e.lat));
            check_output({e.tag, ".res"}, res, e.res);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_output({e.tag, ".hold_res"}, res, e.res);
                check_output({e.tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;

        repeat (2) @(negedge clk);
        check_output("reset.in_ready", 64'(in_ready), 64'd1);
        check_output("reset.out_valid", 64'(out_valid), 64'd0);
        check_output("reset.res", res, 64'd0);
        rst_n = 1'b1;

        apply_stimulus("mul_7_m3", OP_MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, FL);
        apply_stimulus("mul_wide", OP_MUL, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, FL);
        apply_stimulus("mulhu_max", OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, FL);
        apply_stimulus("mulhsu_m1_2", OP_MULHSU, '1, 64'd2, '1, FL);
        apply_stimulus("mulh_neg", OP_MULH, 64'h4000_0000_0000_0000, -64'sd4, '1, FL);
        apply_stimulus("mulh_m1_m1", OP_MULH, '1, '1, 64'd0, FL);
        apply_stimulus("div_m7_2", OP_DIV, -64'sd7, 64'd2, -64'sd3, FL);
        apply_stimulus("rem_m7_2", OP_REM, -64'sd7, 64'd2, -64'sd1, FL);
        apply_stimulus("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, FL);
        apply_stimulus("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, FL);
        apply_stimulus("remu_max_16", OP_REMU, '1, 64'h10, 64'hF, FL);
        apply_stimulus("divu_by0", OP_DIVU, 64'd5, 64'd0, '1, el(FL));
        apply_stimulus("rem_by0", OP_REM, 64'd7, 64'd0, 64'd7, el(FL));
        apply_stimulus("div_m7_by0", OP_DIV, -64'sd7, 64'd0, '1, el(FL));
        apply_stimulus("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, '1, 64'd0, el(FL));
        apply_stimulus("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1,
                       64'h8000_0000_0000_0000, el(FL));
        apply_stimulus("mul_zero", OP_MUL, 64'd0, 64'd5, 64'd0, el(FL));
        apply_stimulus("divuw_sext", OP_DIVUW, 64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, WL);
        apply_stimulus("divuw_pos", OP_DIVUW, 64'hFFFF_FFFE, 64'd2, 64'h7FFF_FFFF, WL);
        apply_stimulus("divw_by0_hi", OP_DIVW, 64'd9, 64'h1_0000_0000, '1, el(WL));
        apply_stimulus("mulw_low", OP_MULW, 64'h1_0000_0003, 64'd5, 64'd15, WL);
        apply_stimulus("mulw_sext", OP_MULW, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, WL);
        apply_stimulus("remw_m7_2", OP_REMW, -64'sd7, 64'd2, '1, WL);
        apply_stimulus("remuw_by0", OP_REMUW, 64'h1_FFFF_FFF9, 64'h1_0000_0000,
                       64'hFFFF_FFFF_FFFF_FFF9, el(WL));
        apply_stimulus("divw_ovf", OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF,
                       64'hFFFF_FFFF_8000_0000, el(WL));
        apply_stimulus("illegal_13", mdu_op_t'(4'd13), 64'd3, 64'd4, 64'd0, 1);
        apply_stimulus("illegal_15", mdu_op_t'(4'd15), 64'd3, 64'd4, 64'd0, 1);
        apply_stimulus("backpressure", OP_MUL, 64'd6, 64'd7, 64'd42, FL, 10);

        // Flush in the fifth CALC cycle: result discarded, unit idle again.
        @(negedge clk);
        op = OP_DIVU;
        a = 64'd100;
        b = 64'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("flush_calc.out_valid", 64'(out_valid), 64'd0);
        check_output("flush_calc.in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output("flush_calc.never_valid", 64'(seen), 64'd0);

        // Flush alongside a request in IDLE blocks the accept.
        @(negedge clk);
        op = OP_DIV;
        a = 64'd50;
        b = 64'd5;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check_output("flush_idle.in_ready", 64'(in_ready), 64'd1);
        check_output("flush_idle.out_valid", 64'(out_valid), 64'd0);

        // Reset pulse mid-CALC returns outputs to reset values immediately.
        @(negedge clk);
        op = OP_MUL;
        a = 64'd3;
        b = 64'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_output("pre_reset.in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_output("mid_reset.in_ready", 64'(in_ready), 64'd1);
        check_output("mid_reset.out_valid", 64'(out_valid), 64'd0);
        check_output("mid_reset.res", res, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output("post_reset.never_valid", 64'(seen), 64'd0);

        apply_stimulus("recover_div", OP_DIV, 64'd100, -64'sd7, -64'sd14, FL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
